// File: rtl/segment_scanner_pkg.sv
// segment_scanner_pkg: glyph table, blank code and segment bit order for the seven-segment display blocks
package segment_scanner_pkg;
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;
  function automatic logic [6:0] glyph(input logic [3:0] nibble);
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
  endfunction
endpackage

// File: rtl/segment_scanner_if.sv
// segment_scanner_if: value/control inputs and display pin outputs of the scanner
interface segment_scanner_if #(parameter int digits = 4);
  logic [4*digits-1:0] value;
  logic load;
  logic [digits-1:0] blank_mask;
  logic suppress_zeros;
  logic [6:0] segments;
  logic [digits-1:0] digit_enable;
  modport master(output value, load, blank_mask, suppress_zeros, input segments, digit_enable);
  modport slave(input value, load, blank_mask, suppress_zeros, output segments, digit_enable);
endinterface

// File: rtl/segment_scanner_glyph.sv
// segment_glyph: hex nibble to active-low seven-segment pattern
module segment_glyph
  import segment_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);
  assign segments = glyph(nibble);
endmodule

// File: rtl/segment_scanner.sv
// segment_scanner: time-multiplexed common-anode display driver with dead time, blanking and zero suppression
module segment_scanner
  import segment_scanner_pkg::*;
#(
  parameter int digits = 4,
  parameter int refresh_count = 1000,
  parameter int dead_cycles = 2
) (
  input logic clock,
  input logic reset_n,
  segment_scanner_if.slave bus
);
  localparam int sw = refresh_count > 1 ? $clog2(refresh_count) : 1;
  localparam int iw = digits > 1 ? $clog2(digits) : 1;
  localparam int dp = 1 << iw;
  logic [4*digits-1:0] buffer;
  logic [sw-1:0] slot_count;
  logic [iw-1:0] index;
  logic [3:0] nib [dp];
  logic [dp-1:0] zero_from;
  logic [dp-1:0] blank_ext;
  logic [6:0] glyph_seg;
  logic slot_wrap;
  logic dark;
  for (genvar g = 0; g < dp; g++) begin : g_nib
    if (g < digits) begin : g_real
      assign nib[g] = buffer[4*g +: 4];
      assign zero_from[g] = ~|buffer[4*digits-1:4*g];
    end else begin : g_pad
      assign nib[g] = '0;
      assign zero_from[g] = 1'b1;
    end
  end
  assign blank_ext = dp'(bus.blank_mask);
  assign slot_wrap = slot_count == sw'(refresh_count - 1);
  assign dark = slot_count < sw'(dead_cycles) | blank_ext[index] |
                (bus.suppress_zeros & (index != '0) & zero_from[index]);
  segment_glyph u_glyph (.nibble(nib[index]), .segments(glyph_seg));
  // display buffer capture, slot prescaler and digit index
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      buffer <= '0;
      slot_count <= '0;
      index <= '0;
    end else begin
      if (bus.load) buffer <= bus.value;
      slot_count <= slot_wrap ? '0 : slot_count + 1'b1;
      if (slot_wrap) index <= index == iw'(digits - 1) ? '0 : index + 1'b1;
    end
  // registered pin drive: dark during dead time or for blanked/suppressed digits
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      bus.segments <= SEG_BLANK;
      bus.digit_enable <= '1;
    end else begin
      bus.segments <= dark ? SEG_BLANK : glyph_seg;
      bus.digit_enable <= dark ? '1 : ~(digits'(1) << index);
    end
endmodule
